// File: rtl/bus_transfer_decoder.sv
// Register-transfer sequencer: drives one source onto the bus for HOLD_CYCLES cycles,
// then strobes the destination write enable for one cycle. Rejects illegal codes.
module bus_transfer_decoder #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req,
  input  logic [4:0]  src_sel,
  input  logic [4:0]  dst_sel,
  output logic        ready,
  output logic [31:0] out_en,
  output logic [31:0] in_en,
  output logic        done,
  output logic        err,
  output logic [15:0] xfer_count
);

  typedef enum logic [1:0] {StIdle, StDrive, StLatch, StErr} state_e;

  localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES);

  state_e      state_q, state_d;
  logic [4:0]  src_q, src_d;
  logic [4:0]  dst_q, dst_d;
  logic [3:0]  hold_q, hold_d;
  logic [15:0] xfer_count_q, xfer_count_d;

  // Sources 0..23 are real drivers; only registers, HI/LO, PC and MDR are writable.
  function automatic logic src_valid(input logic [4:0] code);
    return code <= 5'd23;
  endfunction

  function automatic logic dst_valid(input logic [4:0] code);
    return (code <= 5'd17) || (code == 5'd20) || (code == 5'd21);
  endfunction

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      hold_q       <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      hold_q       <= hold_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    hold_d       = hold_q;
    xfer_count_d = xfer_count_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          src_d = src_sel;
          dst_d = dst_sel;
          if (src_valid(src_sel) && dst_valid(dst_sel)) begin
            hold_d  = HoldInit;
            state_d = StDrive;
          end else begin
            state_d = StErr;
          end
        end
      end
      StDrive: begin
        hold_d = hold_q - 4'd1;
        if (hold_q <= 4'd1) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        // Count commits at the end of LATCH, so a clear during the transfer never counts it.
        if (xfer_count_q != 16'hFFFF) begin
          xfer_count_d = xfer_count_q + 16'd1;
        end
        state_d = StIdle;
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from registered state only; req never reaches them combinationally.
  always_comb begin
    out_en = '0;
    in_en  = '0;
    if (state_q == StDrive || state_q == StLatch) begin
      out_en = 32'd1 << src_q;
    end
    if (state_q == StLatch) begin
      in_en = 32'd1 << dst_q;
    end
  end

  assign ready      = (state_q == StIdle);
  assign done       = (state_q == StLatch);
  assign err        = (state_q == StErr);
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_bus_transfer_decoder.sv
// Scoreboard bench for bus_transfer_decoder: one instance with HOLD_CYCLES=1, one with 3.
module tb_bus_transfer_decoder;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [31:0] oe;
    logic [31:0] ie;
    logic [15:0] cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear [2];
  logic        req [2];
  logic [4:0]  src_sel, dst_sel;
  logic        ready [2];
  logic [31:0] out_en [2];
  logic [31:0] in_en [2];
  logic        done [2];
  logic        err [2];
  logic [15:0] xfer_count [2];

  int vectors = 0;
  int miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [15:0] mcnt [2];

  always #5 clock = ~clock;

  bus_transfer_decoder #(.HOLD_CYCLES(1)) u_dut1 (
    .clock(clock), .clear(clear[0]), .req(req[0]), .src_sel(src_sel), .dst_sel(dst_sel),
    .ready(ready[0]), .out_en(out_en[0]), .in_en(in_en[0]), .done(done[0]), .err(err[0]),
    .xfer_count(xfer_count[0])
  );

  bus_transfer_decoder #(.HOLD_CYCLES(3)) u_dut3 (
    .clock(clock), .clear(clear[1]), .req(req[1]), .src_sel(src_sel), .dst_sel(dst_sel),
    .ready(ready[1]), .out_en(out_en[1]), .in_en(in_en[1]), .done(done[1]), .err(err[1]),
    .xfer_count(xfer_count[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int w, input exp_t e);
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: one-hot every cycle; pop and compare on every done/err pulse.
  always @(negedge clock) begin
    exp_t e;
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("onehot_out[%0d]", w), 32'($onehot0(out_en[w])), 32'd1);
      chk($sformatf("onehot_in[%0d]", w), 32'($onehot0(in_en[w])), 32'd1);
      if (done[w] === 1'b1 || err[w] === 1'b1) begin
        if ((w == 0 ? q0.size() : q1.size()) == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event[%0d]: done=%b err=%b with empty queue", w, done[w],
                   err[w]);
        end else begin
          if (w == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("ev_done[%0d]", w), 32'(done[w]), 32'(e.done));
          chk($sformatf("ev_err[%0d]", w), 32'(err[w]), 32'(e.err));
          chk($sformatf("ev_out_en[%0d]", w), out_en[w], e.oe);
          chk($sformatf("ev_in_en[%0d]", w), in_en[w], e.ie);
          chk($sformatf("ev_count[%0d]", w), 32'(xfer_count[w]), 32'(e.cnt));
        end
      end else begin
        chk($sformatf("in_en_idle[%0d]", w), in_en[w], 32'd0);
      end
    end
  end

  // One request on instance w; exp_oe/exp_ie are the hand-computed enables (0 = reject).
  task automatic xfer(input int w, input logic [4:0] s, input logic [4:0] d,
                      input logic [31:0] exp_oe, input logic [31:0] exp_ie);
    exp_t e;
    int   hold = (w == 0) ? 1 : 3;
    bit   ok = (exp_oe != 32'd0);
    @(negedge clock);
    chk("ready_before_req", 32'(ready[w]), 32'd1);
    src_sel = s;
    dst_sel = d;
    req[w]  = 1'b1;
    e.done = ok;
    e.err  = !ok;
    e.oe   = ok ? exp_oe : 32'd0;
    e.ie   = ok ? exp_ie : 32'd0;
    e.cnt  = mcnt[w];
    push(w, e);
    if (ok && mcnt[w] != 16'hFFFF) mcnt[w] = mcnt[w] + 16'd1;
    @(negedge clock);
    req[w]  = 1'b0;
    src_sel = ~s;
    dst_sel = ~d;
    if (ok) begin
      for (int i = 1; i <= hold + 1; i++) begin
        if (i > 1) @(negedge clock);
        chk($sformatf("out_en_c%0d", i), out_en[w], exp_oe);
        chk($sformatf("in_en_c%0d", i), in_en[w], (i == hold + 1) ? exp_ie : 32'd0);
        chk($sformatf("ready_busy_c%0d", i), 32'(ready[w]), 32'd0);
      end
    end else begin
      chk("err_out_en", out_en[w], 32'd0);
      chk("err_in_en", in_en[w], 32'd0);
      chk("err_ready", 32'(ready[w]), 32'd0);
    end
    @(negedge clock);
    chk("ready_after", 32'(ready[w]), 32'd1);
    chk("count_after", 32'(xfer_count[w]), 32'(mcnt[w]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0] seq_s [9];
    logic [4:0] seq_d [9];
    exp_t e;
    seq_s = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    seq_d = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd20};
    clear[0] = 1'b1; clear[1] = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    src_sel = '0; dst_sel = '0;
    mcnt[0] = '0; mcnt[1] = '0;
    repeat (2) @(negedge clock);
    for (int w = 0; w < 2; w++) begin
      chk("rst_ready", 32'(ready[w]), 32'd1);
      chk("rst_out_en", out_en[w], 32'd0);
      chk("rst_in_en", in_en[w], 32'd0);
      chk("rst_done", 32'(done[w]), 32'd0);
      chk("rst_err", 32'(err[w]), 32'd0);
      chk("rst_count", 32'(xfer_count[w]), 32'd0);
    end
    clear[0] = 1'b0; clear[1] = 1'b0;

    // Basic transfers, boundary codes and self-write.
    xfer(0, 5'd5, 5'd20, 32'h0000_0020, 32'h0010_0000);
    chk("count_first", 32'(xfer_count[0]), 32'd1);
    xfer(1, 5'd21, 5'd3, 32'h0020_0000, 32'h0000_0008);
    xfer(0, 5'd9, 5'd9, 32'h0000_0200, 32'h0000_0200);
    xfer(1, 5'd23, 5'd21, 32'h0080_0000, 32'h0020_0000);
    xfer(0, 5'd16, 5'd17, 32'h0001_0000, 32'h0002_0000);
    xfer(0, 5'd0, 5'd0, 32'h0000_0001, 32'h0000_0001);

    // Rejected codes.
    xfer(0, 5'd25, 5'd3, 32'd0, 32'd0);
    xfer(0, 5'd4, 5'd18, 32'd0, 32'd0);
    xfer(1, 5'd24, 5'd1, 32'd0, 32'd0);
    xfer(1, 5'd0, 5'd22, 32'd0, 32'd0);
    chk("count_after_errs", 32'(xfer_count[0]), 32'd4);

    // Clear during DRIVE on the HOLD_CYCLES=3 instance.
    @(negedge clock);
    src_sel = 5'd2; dst_sel = 5'd7; req[1] = 1'b1;
    @(negedge clock);
    req[1] = 1'b0;
    chk("abort_drive_c1", out_en[1], 32'h0000_0004);
    @(negedge clock);
    clear[1] = 1'b1;
    #1;
    mcnt[1] = '0;
    chk("abort_out_en", out_en[1], 32'd0);
    chk("abort_in_en", in_en[1], 32'd0);
    chk("abort_count", 32'(xfer_count[1]), 32'd0);
    chk("abort_ready", 32'(ready[1]), 32'd1);
    @(posedge clock);
    #2 clear[1] = 1'b0;
    xfer(1, 5'd2, 5'd7, 32'h0000_0004, 32'h0000_0080);
    chk("count_after_abort", 32'(xfer_count[1]), 32'd1);

    // req held high with codes changing every cycle: accepts every HOLD_CYCLES+2 = 3 edges.
    @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      src_sel = seq_s[i];
      dst_sel = seq_d[i];
      req[0]  = 1'b1;
      chk($sformatf("stream_ready_%0d", i), 32'(ready[0]), (i % 3 == 0) ? 32'd1 : 32'd0);
      if (i % 3 == 0) begin
        e.done = 1'b1;
        e.err  = 1'b0;
        e.oe   = 32'd1 << seq_s[i];
        e.ie   = 32'd1 << seq_d[i];
        e.cnt  = mcnt[0];
        push(0, e);
        mcnt[0] = mcnt[0] + 16'd1;
      end
      @(negedge clock);
    end
    req[0] = 1'b0;
    repeat (3) @(negedge clock);
    chk("stream_count", 32'(xfer_count[0]), 32'd7);

    // Saturation from a preloaded count.
    @(negedge clock);
    force u_dut1.xfer_count_q = 16'hFFFE;
    @(negedge clock);
    release u_dut1.xfer_count_q;
    mcnt[0] = 16'hFFFE;
    chk("preload_count", 32'(xfer_count[0]), 32'h0000_FFFE);
    xfer(0, 5'd3, 5'd4, 32'h0000_0008, 32'h0000_0010);
    xfer(0, 5'd20, 5'd21, 32'h0010_0000, 32'h0020_0000);
    xfer(0, 5'd22, 5'd15, 32'h0040_0000, 32'h0000_8000);
    chk("sat_count", 32'(xfer_count[0]), 32'h0000_FFFF);

    repeat (3) @(negedge clock);
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
